vga_sprite_port_arbiter: RTL
============================

VGA_SPRITE_PORT_ARBITER -- requirements
Module: vga_sprite_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: max consecutive cycles a pending B request may be denied during active display (range 1..255).
REQ-002 SHALL have parameter AW, default 12: sprite RAM word-address width of the 16-bit port.
REQ-003 SHALL use one clock and a synchronous, active-high reset; port list: clk  in  1  system clock, all state on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 display_active  in  1  high during VGA visible region.
REQ-006 a_req  in  1  renderer read request; held with a_addr until granted.
REQ-007 a_addr  in  AW  renderer word address.
REQ-008 a_gnt  out  1  renderer request accepted this cycle.
REQ-009 a_rvalid  out  1  a_rdata valid.
REQ-010 a_rdata  out  16  renderer read data.
REQ-011 b_req  in  1  host/blitter request; held with b_* until granted.
REQ-012 b_we  in  1  1 = write, 0 = read.
REQ-013 b_addr  in  AW  host word address.
REQ-014 b_wdata  in  16  host write data.
REQ-015 b_be  in  2  host byte enables.
REQ-016 b_gnt  out  1  host request accepted this cycle.
REQ-017 b_rvalid  out  1  b_rdata valid (reads only).
REQ-018 b_rdata  out  16  host read data.
REQ-019 ram_address  out  AW; ram_chipselect  out  1; ram_write  out  1; ram_writedata  out  16; ram_byteenable  out  2; ram_clken  out  1 (constant 1); ram_readdata  in  16 -- sprite RAM 16-bit port.

Function
REQ-020 At most one of a_gnt/b_gnt SHALL be high per cycle; gnt is combinational from req, display_active and registered state.
REQ-021 On a granted cycle, ram_chipselect=1 and ram_address/ram_write/ram_writedata/ram_byteenable SHALL carry the winner's values (A: write=0, be=2'b11); otherwise chipselect=0, write=0.
REQ-022 Read latency SHALL be 1 cycle: a read granted in cycle N gives x_rvalid=1 and x_rdata=ram_readdata in cycle N+1 only; writes never assert rvalid.
REQ-023 Registered owner state: IDLE, RD_A, RD_B; next state = RD_A/RD_B on granted read, else IDLE; rvalid decoded from it.
REQ-024 display_active=1: A wins ties, except when wait_cnt==MAX_WAIT, then B wins one cycle.
REQ-025 display_active=0: B wins ties.
REQ-026 wait_cnt (8 bit) SHALL increment on each cycle b_req=1 and b_gnt=0, clear on b_gnt or b_req=0, saturate at MAX_WAIT.
REQ-027 A single requester SHALL be granted in the cycle it requests (back-to-back grants allowed, one per cycle).
REQ-028 display_active toggling mid-stream SHALL affect only the same-cycle arbitration; an outstanding read still returns to its owner.

Reset
REQ-029 Reset SHALL force owner=IDLE, wait_cnt=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0; gnt outputs follow REQ-020 with reset state.
REQ-030 Reset asserted the cycle after a granted read SHALL suppress that rvalid.
REQ-031 While reset=1, a_gnt=b_gnt=0 and ram_chipselect=0.

Configuration
REQ-032 Macro VGA_SPRITE_ARB_STARVE_EN defined: REQ-024 starvation override and wait_cnt are built.
REQ-033 Undefined: strict A priority during display (B may starve indefinitely), no wait_cnt logic; all else identical.

Structure
REQ-034 Shared package vga_sprite_pkg SHALL hold owner-state enum, AW default and 16-bit pixel-word typedef.
REQ-035 Single module; no sub-module (starvation counter inline).

Verification
REQ-036 A-only reads addr 0x010,0x011 back-to-back -> a_gnt both cycles, a_rvalid next cycles with RAM contents of 0x010,0x011.
REQ-037 Blanking, a_req+b_req (B write 0xABCD @0x200, be=2'b11) -> b_gnt first, then a_gnt; readback 0x200 = 0xABCD.
REQ-038 Display, A held continuously, B read pending, MAX_WAIT=15, STARVE_EN -> b_gnt in 16th cycle of waiting, then A resumes.
REQ-039 Same as 038 without STARVE_EN -> b_gnt never while A requests; granted after display_active=0.
REQ-040 B byte write be=2'b01 data 0x12FF over 0x3456 -> readback 0x34FF.
REQ-041 Reset pulse the cycle after a granted A read -> a_rvalid=0, owner IDLE, next request granted normally.

Source files
------------

// File: rtl/vga_sprite_pkg.sv
// Shared types for the sprite-RAM port arbiter: owner state, default address width, pixel word.
package vga_sprite_pkg;

    localparam int AW_DEFAULT = 12;

    typedef logic [15:0] pix_word_t;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_RD_A = 2'd1,
        OWN_RD_B = 2'd2
    } owner_e;

endpackage

// File: rtl/vga_sprite_port_arbiter_if.sv
// Renderer (A), host (B) and sprite-RAM signal bundle; slave = arbiter side, master = environment side.
interface vga_sprite_port_arbiter_if #(
    parameter int AW = vga_sprite_pkg::AW_DEFAULT
);
    import vga_sprite_pkg::*;

    logic            display_active;

    logic            a_req;
    logic [AW-1:0]   a_addr;
    logic            a_gnt;
    logic            a_rvalid;
    pix_word_t       a_rdata;

    logic            b_req;
    logic            b_we;
    logic [AW-1:0]   b_addr;
    pix_word_t       b_wdata;
    logic [1:0]      b_be;
    logic            b_gnt;
    logic            b_rvalid;
    pix_word_t       b_rdata;

    logic [AW-1:0]   ram_address;
    logic            ram_chipselect;
    logic            ram_write;
    pix_word_t       ram_writedata;
    logic [1:0]      ram_byteenable;
    logic            ram_clken;
    pix_word_t       ram_readdata;

    modport slave (
        input  display_active,
        input  a_req, a_addr,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata, b_be,
        output b_gnt, b_rvalid, b_rdata,
        output ram_address, ram_chipselect, ram_write, ram_writedata, ram_byteenable, ram_clken,
        input  ram_readdata
    );

    modport master (
        output display_active,
        output a_req, a_addr,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata, b_be,
        input  b_gnt, b_rvalid, b_rdata,
        input  ram_address, ram_chipselect, ram_write, ram_writedata, ram_byteenable, ram_clken,
        output ram_readdata
    );

endinterface

// File: rtl/vga_sprite_port_arbiter.sv
// Two-requester arbiter for the 16-bit sprite-RAM port: same-cycle grant, 1-cycle read return, requesters hold until granted.
// VGA_SPRITE_ARB_STARVE_EN builds the host anti-starvation counter (otherwise strict renderer priority in display).
module vga_sprite_port_arbiter
    import vga_sprite_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int AW       = AW_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    vga_sprite_port_arbiter_if.slave   bus
);

    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("MAX_WAIT must be in 1..255");
    end

    owner_e        own_q, own_d;
    logic          a_gnt, b_gnt;
    logic          starve;
    logic [AW-1:0] addr_mux;

`ifdef VGA_SPRITE_ARB_STARVE_EN
    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    logic [7:0] wait_q, wait_d;

    assign starve = (wait_q == WAIT_LIM);

    // Counts consecutive refused cycles of a pending host request.
    always_comb begin
        wait_d = 8'd0;
        if (bus.b_req && !b_gnt) begin
            wait_d = starve ? wait_q : wait_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q <= 8'd0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign starve = 1'b0;
`endif

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!reset) begin
            if (bus.a_req && bus.b_req) begin
                if (bus.display_active && !starve) begin
                    a_gnt = 1'b1;
                end else begin
                    b_gnt = 1'b1;
                end
            end else begin
                a_gnt = bus.a_req;
                b_gnt = bus.b_req;
            end
        end
    end

    assign addr_mux           = b_gnt ? bus.b_addr : bus.a_addr;

    assign bus.a_gnt          = a_gnt;
    assign bus.b_gnt          = b_gnt;
    assign bus.ram_chipselect = a_gnt | b_gnt;
    assign bus.ram_address    = addr_mux;
    assign bus.ram_write      = b_gnt & bus.b_we;
    assign bus.ram_writedata  = b_gnt ? bus.b_wdata : 16'h0000;
    assign bus.ram_byteenable = b_gnt ? bus.b_be : 2'b11;
    assign bus.ram_clken      = 1'b1;

    always_comb begin
        own_d = OWN_IDLE;
        if (a_gnt) begin
            own_d = OWN_RD_A;
        end else if (b_gnt && !bus.b_we) begin
            own_d = OWN_RD_B;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            own_q <= OWN_IDLE;
        end else begin
            own_q <= own_d;
        end
    end

    // Reset gates the return combinationally so a read granted just before reset never surfaces.
    assign bus.a_rvalid = (own_q == OWN_RD_A) && !reset;
    assign bus.b_rvalid = (own_q == OWN_RD_B) && !reset;
    assign bus.a_rdata  = bus.a_rvalid ? bus.ram_readdata : 16'h0000;
    assign bus.b_rdata  = bus.b_rvalid ? bus.ram_readdata : 16'h0000;

endmodule
